// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common data bus (CDB): default tag/data widths,
// the tag value driven on an idle CDB port, and the broadcast beat type used
// by the CDB arbiter, the reservation stations and the ROB.
// No ports (package).
// -----------------------------------------------------------------------------
package cdb_pkg;

    localparam int CDB_ROB_W  = 6;
    localparam int CDB_DATA_W = 32;

    // Tag presented on a CDB port that carries no result this cycle.
    localparam logic [CDB_ROB_W-1:0] CDB_INVALID_ROB = 6'b010000;

    // One CDB broadcast as seen by consumers.
    typedef struct packed {
        logic                  iscast;
        logic [CDB_ROB_W-1:0]  rob;
        logic [CDB_DATA_W-1:0] data;
    } cdb_beat_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the producer handshake and both CDB broadcast ports of cdb_arbiter.
//   master : result producers / bench (drive req_*, observe ready and CDB)
//   slave  : cdb_arbiter (accepts req_*, drives ready, CDB ports, debug ptr)
// Signals:
//   req_valid/req_rob/req_data  per-producer offer, slice i = producer i
//   req_ready                   per-producer accept (combinational)
//   CDBiscast/CDBrobNum/CDBdata       CDB port 1 (registered)
//   CDBiscast2/CDBrobNum2/CDBdata2    CDB port 2 (registered)
//   dbg_rr_ptr                  current rotating-priority pointer
//
// Handshake: a result moves from producer i into its holding slot at the
// rising clock edge where req_valid[i] && req_ready[i]. While req_valid[i] is
// high and req_ready[i] is low the producer keeps req_valid, its tag and its
// data stable. req_ready[i] does not depend on req_valid[i].
// -----------------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ROB_W   = CDB_ROB_W,
    parameter int DATA_W  = CDB_DATA_W
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ROB_W-1:0]  req_rob;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      CDBiscast;
    logic [ROB_W-1:0]          CDBrobNum;
    logic [DATA_W-1:0]         CDBdata;
    logic                      CDBiscast2;
    logic [ROB_W-1:0]          CDBrobNum2;
    logic [DATA_W-1:0]         CDBdata2;

    logic [PTR_W-1:0]          dbg_rr_ptr;

    modport master (
        output req_valid, req_rob, req_data,
        input  req_ready,
        input  CDBiscast, CDBrobNum, CDBdata,
        input  CDBiscast2, CDBrobNum2, CDBdata2,
        input  dbg_rr_ptr
    );

    modport slave (
        input  req_valid, req_rob, req_data,
        output req_ready,
        output CDBiscast, CDBrobNum, CDBdata,
        output CDBiscast2, CDBrobNum2, CDBdata2,
        output dbg_rr_ptr
    );
endinterface

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational rotating-priority picker. Scans the occupancy vector starting
// at ptr (wrapping modulo N); the first occupied entry is grant 1, the second
// is grant 2. next_ptr is one past the last granted index, or ptr when
// nothing is granted.
// Build option: CDB_DUAL_BUS_EN defined enables the second grant; undefined,
// gnt2/vld2 are constant 0 and next_ptr moves past the single winner.
// Ports:
//   occ      in  N      occupied entries
//   ptr      in  PTR_W  scan start index
//   gnt1     out N      one-hot first grant
//   gnt2     out N      one-hot second grant
//   vld1     out 1      gnt1 is meaningful
//   vld2     out 1      gnt2 is meaningful
//   next_ptr out PTR_W  pointer for the next cycle
// -----------------------------------------------------------------------------
module rr_pick2 #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     occ,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt1,
    output logic [N-1:0]     gnt2,
    output logic             vld1,
    output logic             vld2,
    output logic [PTR_W-1:0] next_ptr
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] idx_next;
        gnt1     = '0;
        gnt2     = '0;
        vld1     = 1'b0;
        vld2     = 1'b0;
        next_ptr = ptr;
        idx      = ptr;
        for (int k = 0; k < N; k++) begin
            // idx walks ptr, ptr+1, ... with an explicit wrap so non-power-of-two
            // N never produces an out-of-range index.
            idx_next = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
            if (occ[idx]) begin
                if (!vld1) begin
                    gnt1[idx] = 1'b1;
                    vld1      = 1'b1;
                    next_ptr  = idx_next;
                end
`ifdef CDB_DUAL_BUS_EN
                else if (!vld2) begin
                    gnt2[idx] = 1'b1;
                    vld2      = 1'b1;
                    next_ptr  = idx_next;
                end
`endif
            end
            idx = idx_next;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares CDB port 1 and port 2 among NUM_REQ result producers. Each producer
// owns a one-entry holding slot filled through a valid/ready handshake; a
// rotating-priority picker broadcasts up to two held results per cycle on
// registered CDB outputs. flush discards every held result and idles the CDB.
// Build option: CDB_DUAL_BUS_EN defined gives two grants per cycle; undefined,
// only port 1 is used and port 2 is tied idle.
// Ports:
//   clock  in   single clock, posedge
//   reset  in   asynchronous, active-low
//   flush  in   synchronous mispredict flush (highest priority)
//   bus    slave modport of cdb_arbiter_if (producer handshake, CDB ports,
//          debug view of the rotating pointer)
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int               NUM_REQ     = 4,
    parameter int               ROB_W       = CDB_ROB_W,
    parameter int               DATA_W      = CDB_DATA_W,
    parameter logic [ROB_W-1:0] INVALID_ROB = ROB_W'(CDB_INVALID_ROB)
) (
    input logic          clock,
    input logic          reset,
    input logic          flush,
    cdb_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] slot_vld;
    logic [ROB_W-1:0]   slot_rob  [NUM_REQ];
    logic [DATA_W-1:0]  slot_data [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;

    logic [NUM_REQ-1:0] gnt1, gnt2, gnt_any, accept;
    logic               vld1, vld2;
    logic [ROB_W-1:0]   pick1_rob,  pick2_rob;
    logic [DATA_W-1:0]  pick1_data, pick2_data;

    logic               cdb1_cast;
    logic [ROB_W-1:0]   cdb1_rob;
    logic [DATA_W-1:0]  cdb1_data;

    rr_pick2 #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .occ      (slot_vld),
        .ptr      (rr_ptr),
        .gnt1     (gnt1),
        .gnt2     (gnt2),
        .vld1     (vld1),
        .vld2     (vld2),
        .next_ptr (next_ptr)
    );

    // A grant vector only counts together with its valid bit.
    assign gnt_any = (vld1 ? gnt1 : '0) | (vld2 ? gnt2 : '0);

    // A slot being drained this cycle can take a new result at the same edge.
    assign bus.req_ready = flush ? '0 : (~slot_vld | gnt_any);
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.dbg_rr_ptr = rr_ptr;

    // One-hot grant muxes: OR of the selected slot contents.
    always_comb begin
        pick1_rob  = '0;
        pick1_data = '0;
        pick2_rob  = '0;
        pick2_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt1[i]) begin
                pick1_rob  = pick1_rob  | slot_rob[i];
                pick1_data = pick1_data | slot_data[i];
            end
            if (gnt2[i]) begin
                pick2_rob  = pick2_rob  | slot_rob[i];
                pick2_data = pick2_data | slot_data[i];
            end
        end
    end

    // Holding slots: refill beats the clear of a granted slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_vld <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_rob[i]  <= '0;
                slot_data[i] <= '0;
            end
        end else if (flush) begin
            slot_vld <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_rob[i]  <= bus.req_rob[i*ROB_W +: ROB_W];
                    slot_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
                end else if (gnt_any[i]) begin
                    slot_vld[i]  <= 1'b0;
                end
            end
        end
    end

    // The picker returns the current pointer when nothing is granted, so the
    // pointer only has to be frozen during flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (!flush) begin
            rr_ptr <= next_ptr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb1_cast <= 1'b0;
            cdb1_rob  <= INVALID_ROB;
            cdb1_data <= '0;
        end else if (flush || !vld1) begin
            cdb1_cast <= 1'b0;
            cdb1_rob  <= INVALID_ROB;
            cdb1_data <= '0;
        end else begin
            cdb1_cast <= 1'b1;
            cdb1_rob  <= pick1_rob;
            cdb1_data <= pick1_data;
        end
    end

    assign bus.CDBiscast = cdb1_cast;
    assign bus.CDBrobNum = cdb1_rob;
    assign bus.CDBdata   = cdb1_data;

`ifdef CDB_DUAL_BUS_EN
    logic              cdb2_cast;
    logic [ROB_W-1:0]  cdb2_rob;
    logic [DATA_W-1:0] cdb2_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb2_cast <= 1'b0;
            cdb2_rob  <= INVALID_ROB;
            cdb2_data <= '0;
        end else if (flush || !vld2) begin
            cdb2_cast <= 1'b0;
            cdb2_rob  <= INVALID_ROB;
            cdb2_data <= '0;
        end else begin
            cdb2_cast <= 1'b1;
            cdb2_rob  <= pick2_rob;
            cdb2_data <= pick2_data;
        end
    end

    assign bus.CDBiscast2 = cdb2_cast;
    assign bus.CDBrobNum2 = cdb2_rob;
    assign bus.CDBdata2   = cdb2_data;
`else
    // Port 2 is permanently idle; its mux result has no consumer.
    logic unused_pick2;
    assign unused_pick2 = ^{pick2_rob, pick2_data};

    assign bus.CDBiscast2 = 1'b0;
    assign bus.CDBrobNum2 = INVALID_ROB;
    assign bus.CDBdata2   = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter. A behavioural model (per-producer slots,
// rotating scan, registered CDB beats) is compared against the DUT on every
// falling edge; directed sections add hand-computed literal expectations.
// Works for both builds of CDB_DUAL_BUS_EN.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NREQ = 4;
    localparam int RW   = 6;
    localparam int DW   = 32;
    localparam logic [RW-1:0] INV = 6'b010000;
`ifdef CDB_DUAL_BUS_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic clock;
    logic reset;
    logic flush;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;
    logic [RW-1:0] exp_q[$];

    cdb_arbiter_if #(.NUM_REQ(NREQ), .ROB_W(RW), .DATA_W(DW)) bus();

    cdb_arbiter #(
        .NUM_REQ (NREQ),
        .ROB_W   (RW),
        .DATA_W  (DW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_vld  [NREQ];
    logic [RW-1:0] m_rob  [NREQ];
    logic [DW-1:0] m_data [NREQ];
    int            m_ptr;
    logic          m_c1_cast, m_c2_cast;
    logic [RW-1:0] m_c1_rob,  m_c2_rob;
    logic [DW-1:0] m_c1_data, m_c2_data;

    // Winners of the current cycle: occupied slots in scan order from m_ptr.
    function automatic void pick(output int g1, output int g2);
        int order[$];
        order = {};
        for (int k = 0; k < NREQ; k++)
            if (m_vld[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
        g1 = (order.size() > 0) ? order[0] : -1;
        g2 = (DUAL && order.size() > 1) ? order[1] : -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        int g1, g2;
        bit acc [NREQ];
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) m_vld[i] = 1'b0;
            m_ptr = 0;
            m_c1_cast = 1'b0; m_c1_rob = INV; m_c1_data = '0;
            m_c2_cast = 1'b0; m_c2_rob = INV; m_c2_data = '0;
        end else if (flush) begin
            for (int i = 0; i < NREQ; i++) m_vld[i] = 1'b0;
            m_c1_cast = 1'b0; m_c1_rob = INV; m_c1_data = '0;
            m_c2_cast = 1'b0; m_c2_rob = INV; m_c2_data = '0;
        end else begin
            pick(g1, g2);
            for (int i = 0; i < NREQ; i++)
                acc[i] = bus.req_valid[i] && (!m_vld[i] || i == g1 || i == g2);
            if (g1 >= 0) begin
                m_c1_cast = 1'b1; m_c1_rob = m_rob[g1]; m_c1_data = m_data[g1];
            end else begin
                m_c1_cast = 1'b0; m_c1_rob = INV; m_c1_data = '0;
            end
            if (g2 >= 0) begin
                m_c2_cast = 1'b1; m_c2_rob = m_rob[g2]; m_c2_data = m_data[g2];
            end else begin
                m_c2_cast = 1'b0; m_c2_rob = INV; m_c2_data = '0;
            end
            if (g2 >= 0)      m_ptr = (g2 + 1) % NREQ;
            else if (g1 >= 0) m_ptr = (g1 + 1) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (i == g1 || i == g2) m_vld[i] = 1'b0;
                if (acc[i]) begin
                    m_vld[i]  = 1'b1;
                    m_rob[i]  = bus.req_rob[i*RW +: RW];
                    m_data[i] = bus.req_data[i*DW +: DW];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        int g1, g2;
        logic [NREQ-1:0] er;
        if (chk_en) begin
            pick(g1, g2);
            for (int i = 0; i < NREQ; i++)
                er[i] = !flush && (!m_vld[i] || i == g1 || i == g2);
            check("req_ready",  bus.req_ready,  er);
            check("cdb1_cast",  bus.CDBiscast,  m_c1_cast);
            check("cdb1_rob",   bus.CDBrobNum,  m_c1_rob);
            check("cdb1_data",  bus.CDBdata,    m_c1_data);
            check("cdb2_cast",  bus.CDBiscast2, m_c2_cast);
            check("cdb2_rob",   bus.CDBrobNum2, m_c2_rob);
            check("cdb2_data",  bus.CDBdata2,   m_c2_data);
            check("rr_ptr",     bus.dbg_rr_ptr, m_ptr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_rob[i*RW +: RW]  = r;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
    endtask

    // Offer one result on producer i for one cycle, then let it drain.
    task automatic send_one(input int i, input logic [RW-1:0] r, input logic [DW-1:0] d);
        tick();
        set_req(i, 1'b1, r, d);
        tick();
        set_req(i, 1'b0, '0, '0);
        tick();
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_rob   = '0;
        bus.req_data  = '0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        chk_en = 1'b1;

        // Reset state
        #1;
        check("rst_cast1", bus.CDBiscast, 1'b0);
        check("rst_rob1",  bus.CDBrobNum, 6'b010000);
        check("rst_data1", bus.CDBdata, 32'h0);
        check("rst_cast2", bus.CDBiscast2, 1'b0);
        check("rst_rob2",  bus.CDBrobNum2, 6'b010000);
        check("rst_ready", bus.req_ready, 4'hf);
        check("rst_ptr",   bus.dbg_rr_ptr, 2'd0);

        // Single accept: in at edge 1, on the CDB after edge 2, idle after edge 3
        tick();
        set_req(0, 1'b1, 6'd5, 32'h1234);
        tick();
        set_req(0, 1'b0, '0, '0);
        tick();
        check("single_cast", bus.CDBiscast, 1'b1);
        check("single_rob",  bus.CDBrobNum, 6'd5);
        check("single_data", bus.CDBdata, 32'h1234);
        check("single_p2",   bus.CDBrobNum2, 6'b010000);
        check("single_c2",   bus.CDBiscast2, 1'b0);
        tick();
        check("single_idle", bus.CDBiscast, 1'b0);
        check("single_idle_rob", bus.CDBrobNum, 6'b010000);

        // Move pointer to 0 by granting slot 3 alone
        send_one(3, 6'd11, 32'h33);
        check("ptr_after_3", bus.dbg_rr_ptr, 2'd0);

        // Full contention, tags 1..4 held every cycle
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, RW'(i + 1), DW'(32'h100 + i));
        tick();
        #1;
`ifdef CDB_DUAL_BUS_EN
        check("cont_ready", bus.req_ready, 4'b0011);
        exp_q = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd1, 6'd2};
        while (exp_q.size() > 0) begin
            tick();
            check("cont_p1", bus.CDBrobNum,  exp_q.pop_front());
            check("cont_p2", bus.CDBrobNum2, exp_q.pop_front());
        end
`else
        check("cont_ready", bus.req_ready, 4'b0001);
        exp_q = '{6'd1, 6'd2, 6'd3, 6'd4};
        while (exp_q.size() > 0) begin
            tick();
            check("cont_p1", bus.CDBrobNum, exp_q.pop_front());
            check("cont_p2", bus.CDBrobNum2, 6'b010000);
        end
`endif
        clear_reqs();
        repeat (6) tick();

        // Move pointer to 3 by granting slot 2 alone
        send_one(2, 6'd12, 32'h22);
        check("ptr_after_2", bus.dbg_rr_ptr, 2'd3);

        // Wrap-around: ptr=3, slots 3 (tag 9) and 0 (tag 7)
        set_req(3, 1'b1, 6'd9, 32'h99);
        set_req(0, 1'b1, 6'd7, 32'h77);
        tick();
        clear_reqs();
        tick();
        check("wrap_p1", bus.CDBrobNum, 6'd9);
        check("wrap_d1", bus.CDBdata, 32'h99);
`ifdef CDB_DUAL_BUS_EN
        check("wrap_p2",  bus.CDBrobNum2, 6'd7);
        check("wrap_ptr", bus.dbg_rr_ptr, 2'd1);
`else
        check("wrap_p2",  bus.CDBrobNum2, 6'b010000);
        check("wrap_ptr", bus.dbg_rr_ptr, 2'd0);
        tick();
        check("wrap_p1b",  bus.CDBrobNum, 6'd7);
        check("wrap_ptrb", bus.dbg_rr_ptr, 2'd1);
`endif
        repeat (2) tick();

        // Flush with three full slots
        set_req(0, 1'b1, 6'd20, 32'h200);
        set_req(1, 1'b1, 6'd21, 32'h201);
        set_req(2, 1'b1, 6'd22, 32'h202);
        tick();
        clear_reqs();
        flush = 1'b1;
        #1;
        check("flush_ready", bus.req_ready, 4'h0);
        tick();
        flush = 1'b0;
        check("flush_cast1", bus.CDBiscast, 1'b0);
        check("flush_rob1",  bus.CDBrobNum, 6'b010000);
        check("flush_cast2", bus.CDBiscast2, 1'b0);
        check("flush_rob2",  bus.CDBrobNum2, 6'b010000);
        check("flush_ptr",   bus.dbg_rr_ptr, 2'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_flush_c1", bus.CDBiscast, 1'b0);
            check("post_flush_c2", bus.CDBiscast2, 1'b0);
        end

        // Asynchronous reset while a broadcast is on the bus
        set_req(1, 1'b1, 6'd33, 32'hABCD);
        set_req(2, 1'b1, 6'd34, 32'hABCE);
        set_req(3, 1'b1, 6'd35, 32'hABCF);
        tick();
        clear_reqs();
        tick();
        check("pre_rst_cast", bus.CDBiscast, 1'b1);
        check("pre_rst_rob",  bus.CDBrobNum, 6'd33);
        #2 reset = 1'b0;
        #1;
        check("arst_cast1", bus.CDBiscast, 1'b0);
        check("arst_rob1",  bus.CDBrobNum, 6'b010000);
        check("arst_cast2", bus.CDBiscast2, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("rel_ready", bus.req_ready, 4'hf);
        check("rel_ptr",   bus.dbg_rr_ptr, 2'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_c1", bus.CDBiscast, 1'b0);
            check("post_rst_c2", bus.CDBiscast2, 1'b0);
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
